// File: rtl/fifo_playback_pkg.sv
// Shared types and elaboration helpers for the FIFO playback sequencer.
package fifo_playback_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      REQUEUE,
      HOLD
   } state_t;

   // Number of clock cycles per displayed entry, rounded to nearest.
   function automatic int step_cycles(input real clk_frequency, input real step_time);
      return int'($rtoi(clk_frequency * step_time + 0.5));
   endfunction

   function automatic int counter_width(input int max_value);
      return (max_value < 1) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/fifo_playback_timer.sv
// Loadable down-counter that paces the Hold phase; done is high while the count is zero.
module fifo_playback_timer
   import fifo_playback_pkg::*;
#(
   parameter int STEP_CYCLES = 4
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  load,
   input  logic [counter_width(STEP_CYCLES)-1:0] load_value,
   input  logic                                  enable,
   output logic                                  done
);

   localparam int W = counter_width(STEP_CYCLES);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && count != '0) begin
         count <= count - W'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/fifo_playback_ctrl.sv
// Records values into an attached Valid/Ready FIFO and plays them back on the LEDs,
// one entry per step, optionally writing each played entry back to the FIFO tail.
module fifo_playback_ctrl
   import fifo_playback_pkg::*;
#(
   parameter int  WIDTH         = 4,
   parameter int  DEPTH         = 4096,
   parameter real CLK_FREQUENCY = 125.0e6,
   parameter real STEP_TIME     = 0.5
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            record,
   input  logic                            play,
   input  logic                            stop,
   input  logic                            loop,
   input  logic [WIDTH-1:0]                in_value,
   output logic [WIDTH-1:0]                fifo_in_data,
   output logic                            fifo_in_valid,
   input  logic                            fifo_in_ready,
   input  logic [WIDTH-1:0]                fifo_out_data,
   input  logic                            fifo_out_valid,
   output logic                            fifo_out_ready,
   output logic [WIDTH-1:0]                led,
   output logic                            playing,
   output logic [counter_width(DEPTH)-1:0] entries,
   output logic                            dropped
);

   localparam int STEP_CYCLES = step_cycles(CLK_FREQUENCY, STEP_TIME);
   localparam int TIMER_W     = counter_width(STEP_CYCLES);
   localparam int ENTRIES_W   = counter_width(DEPTH);
   localparam logic [TIMER_W-1:0]   RELOAD      = TIMER_W'(STEP_CYCLES - 3);
   localparam logic [ENTRIES_W-1:0] ENTRIES_MAX = ENTRIES_W'(DEPTH);

   if (STEP_CYCLES < 3) begin : g_step_check
      $error("fifo_playback_ctrl: step time must cover at least 3 clock cycles");
   end

   state_t               state;
   state_t               state_next;
   logic                 stop_q;
   logic                 loop_q;
   logic [WIDTH-1:0]     requeue_q;
   logic [WIDTH-1:0]     led_q;
   logic                 dropped_q;
   logic [ENTRIES_W-1:0] entries_q;
   logic                 drop_req;
   logic                 timer_load;
   logic                 timer_enable;
   logic                 timer_done;
   logic                 wr_accept;
   logic                 rd_accept;

   fifo_playback_timer #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (timer_load),
      .load_value(RELOAD),
      .enable    (timer_enable),
      .done      (timer_done)
   );

   always_comb begin
      state_next     = state;
      fifo_in_valid  = 1'b0;
      fifo_in_data   = '0;
      fifo_out_ready = 1'b0;
      timer_load     = 1'b0;
      timer_enable   = 1'b0;
      drop_req       = 1'b0;
      case (state)
         IDLE: begin
            // Record wins over a simultaneous Play.
            if (record) begin
               if (fifo_in_ready) begin
                  fifo_in_valid = 1'b1;
                  fifo_in_data  = in_value;
               end else begin
                  drop_req = 1'b1;
               end
            end else if (play && fifo_out_valid) begin
               state_next = FETCH;
            end
         end
         FETCH: begin
            fifo_out_ready = 1'b1;
            drop_req       = record;
            state_next     = REQUEUE;
         end
         REQUEUE: begin
            timer_load = 1'b1;
            drop_req   = record;
            if (loop_q) begin
               fifo_in_valid = 1'b1;
               fifo_in_data  = requeue_q;
               if (!fifo_in_ready) begin
                  drop_req = 1'b1;
               end
            end
            state_next = (stop_q || stop) ? IDLE : HOLD;
         end
         HOLD: begin
            timer_enable = 1'b1;
            drop_req     = record;
            if (stop) begin
               state_next = IDLE;
            end else if (timer_done) begin
               state_next = fifo_out_valid ? FETCH : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign wr_accept = fifo_in_valid && fifo_in_ready;
   assign rd_accept = fifo_out_ready && fifo_out_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         stop_q    <= 1'b0;
         loop_q    <= 1'b0;
         requeue_q <= '0;
         led_q     <= '0;
         dropped_q <= 1'b0;
         entries_q <= '0;
      end else begin
         state     <= state_next;
         dropped_q <= drop_req;
         stop_q    <= (state == FETCH) && stop;
         if (state == FETCH) begin
            loop_q    <= loop;
            led_q     <= fifo_out_data;
            requeue_q <= fifo_out_data;
         end
         // A simultaneous read and write leave the occupancy unchanged.
         if (wr_accept && !rd_accept && entries_q != ENTRIES_MAX) begin
            entries_q <= entries_q + ENTRIES_W'(1);
         end else if (rd_accept && !wr_accept && entries_q != '0) begin
            entries_q <= entries_q - ENTRIES_W'(1);
         end
      end
   end

   assign led     = led_q;
   assign playing = (state != IDLE);
   assign entries = entries_q;
   assign dropped = dropped_q;

endmodule

// File: tb/tb_fifo_playback_ctrl.sv
// Directed bench for fifo_playback_ctrl with a behavioural depth-4 FIFO and a scoreboard of expected LED values.
module tb_fifo_playback_ctrl;

   localparam int WIDTH     = 4;
   localparam int DEPTH     = 4;
   localparam int ENTRIES_W = $clog2(DEPTH + 1);

   logic                 clk;
   logic                 rst_n;
   logic                 record;
   logic                 play;
   logic                 stop;
   logic                 loop;
   logic [WIDTH-1:0]     in_value;
   logic [WIDTH-1:0]     fifo_in_data;
   logic                 fifo_in_valid;
   logic                 fifo_in_ready;
   logic [WIDTH-1:0]     fifo_out_data;
   logic                 fifo_out_valid;
   logic                 fifo_out_ready;
   logic [WIDTH-1:0]     led;
   logic                 playing;
   logic [ENTRIES_W-1:0] entries;
   logic                 dropped;

   logic [WIDTH-1:0] exp_q[$];
   int               n_checks;
   int               n_fail;

   fifo_playback_ctrl #(
      .WIDTH        (WIDTH),
      .DEPTH        (DEPTH),
      .CLK_FREQUENCY(1.0e3),
      .STEP_TIME    (4.0e-3)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .record        (record),
      .play          (play),
      .stop          (stop),
      .loop          (loop),
      .in_value      (in_value),
      .fifo_in_data  (fifo_in_data),
      .fifo_in_valid (fifo_in_valid),
      .fifo_in_ready (fifo_in_ready),
      .fifo_out_data (fifo_out_data),
      .fifo_out_valid(fifo_out_valid),
      .fifo_out_ready(fifo_out_ready),
      .led           (led),
      .playing       (playing),
      .entries       (entries),
      .dropped       (dropped)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural synchronous FIFO standing in for the real one on the board.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [1:0]       wr_ptr;
   logic [1:0]       rd_ptr;
   logic [2:0]       count;
   logic             fifo_wr;
   logic             fifo_rd;

   assign fifo_in_ready  = (count < 3'(DEPTH));
   assign fifo_out_valid = (count != 3'd0);
   assign fifo_out_data  = mem[rd_ptr];
   assign fifo_wr        = fifo_in_valid && fifo_in_ready;
   assign fifo_rd        = fifo_out_ready && fifo_out_valid;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (fifo_wr) begin
            mem[wr_ptr] <= fifo_in_data;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (fifo_rd) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         if (fifo_wr && !fifo_rd) begin
            count <= count + 3'd1;
         end else if (fifo_rd && !fifo_wr) begin
            count <= count - 3'd1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rec, input logic ply, input logic stp, input logic [WIDTH-1:0] val);
      record   = rec;
      play     = ply;
      stop     = stp;
      in_value = val;
   endtask

   task automatic recordValue(input logic [WIDTH-1:0] v, input bit expect_accept);
      applyStimulus(1'b1, 1'b0, 1'b0, v);
      #1;
      checkOutput("record_valid", fifo_in_valid, expect_accept);
      if (expect_accept) begin
         checkOutput("record_data", fifo_in_data, v);
         exp_q.push_back(v);
      end
      cycle();
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("record_dropped", dropped, !expect_accept);
   endtask

   // Leaves the bench in the Fetch cycle of the first entry.
   task automatic startPlay();
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      cycle();
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("fetch_ready", fifo_out_ready, 1'b1);
   endtask

   // Starts in a Fetch cycle, checks the four display cycles, ends in the next Fetch or Idle.
   task automatic checkEntry(input bit last);
      logic [WIDTH-1:0] e;
      e = exp_q.pop_front();
      if (loop) exp_q.push_back(e);
      for (int k = 0; k < 4; k++) begin
         cycle();
         checkOutput("led", led, e);
         if (k == 1) checkOutput("entries_hold", entries, exp_q.size());
         if (k == 3) checkOutput("playing_step_end", playing, !last);
      end
   endtask

   initial begin
      logic [WIDTH-1:0] e;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      loop     = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      cycle();
      cycle();
      checkOutput("reset_led", led, 0);
      checkOutput("reset_playing", playing, 0);
      checkOutput("reset_entries", entries, 0);
      checkOutput("reset_dropped", dropped, 0);
      checkOutput("reset_in_valid", fifo_in_valid, 0);
      checkOutput("reset_out_ready", fifo_out_ready, 0);
      rst_n = 1'b1;
      cycle();

      $display("[TB] record 3,5,9 and play once");
      recordValue(4'd3, 1'b1);
      recordValue(4'd5, 1'b1);
      recordValue(4'd9, 1'b1);
      checkOutput("entries_three", entries, 3);
      startPlay();
      checkEntry(1'b0);
      checkEntry(1'b0);
      checkEntry(1'b1);
      checkOutput("entries_drained", entries, 0);

      $display("[TB] loop playback then stop in hold");
      loop = 1'b1;
      recordValue(4'd1, 1'b1);
      recordValue(4'd2, 1'b1);
      startPlay();
      for (int i = 0; i < 4; i++) checkEntry(1'b0);
      cycle();
      e = exp_q.pop_front();
      exp_q.push_back(e);
      checkOutput("loop_led_5th", led, e);
      cycle();
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
      cycle();
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("stop_hold_playing", playing, 0);
      checkOutput("stop_hold_entries", entries, 2);
      checkOutput("stop_hold_led", led, 1);
      loop = 1'b0;
      startPlay();
      checkEntry(1'b0);
      checkEntry(1'b1);

      $display("[TB] overfill depth-4 FIFO");
      recordValue(4'd10, 1'b1);
      recordValue(4'd11, 1'b1);
      recordValue(4'd12, 1'b1);
      recordValue(4'd13, 1'b1);
      recordValue(4'd14, 1'b0);
      checkOutput("full_entries", entries, 4);
      cycle();
      checkOutput("full_dropped_once", dropped, 0);

      $display("[TB] record during hold, play with empty FIFO");
      startPlay();
      checkEntry(1'b0);
      e = exp_q.pop_front();
      cycle();
      checkOutput("hold_rec_led_a", led, e);
      cycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd7);
      #1;
      checkOutput("hold_rec_valid", fifo_in_valid, 0);
      cycle();
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("hold_rec_dropped", dropped, 1);
      checkOutput("hold_rec_led_b", led, e);
      checkOutput("hold_rec_entries", entries, exp_q.size());
      cycle();
      checkOutput("hold_rec_led_c", led, e);
      checkOutput("hold_rec_dropped_end", dropped, 0);
      checkEntry(1'b0);
      checkEntry(1'b1);
      checkOutput("empty_entries", entries, 0);
      checkOutput("empty_fifo", fifo_out_valid, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      cycle();
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("empty_play_playing", playing, 0);
      checkOutput("empty_play_ready", fifo_out_ready, 0);
      cycle();
      checkOutput("empty_play_idle", playing, 0);

      $display("[TB] stop during fetch with loop");
      loop = 1'b1;
      recordValue(4'd6, 1'b1);
      recordValue(4'd8, 1'b1);
      startPlay();
      applyStimulus(1'b0, 1'b0, 1'b1, '0);
      cycle();
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      e = exp_q.pop_front();
      exp_q.push_back(e);
      checkOutput("stopf_in_valid", fifo_in_valid, 1);
      checkOutput("stopf_in_data", fifo_in_data, e);
      checkOutput("stopf_led", led, e);
      checkOutput("stopf_playing_rq", playing, 1);
      cycle();
      checkOutput("stopf_playing_idle", playing, 0);
      checkOutput("stopf_entries", entries, 2);
      loop = 1'b0;
      startPlay();
      checkEntry(1'b0);
      checkEntry(1'b1);

      $display("[TB] asynchronous reset in hold");
      recordValue(4'd4, 1'b1);
      recordValue(4'd3, 1'b1);
      startPlay();
      cycle();
      applyStimulus(1'b1, 1'b0, 1'b0, 4'd9);
      cycle();
      applyStimulus(1'b0, 1'b0, 1'b0, '0);
      checkOutput("prerst_dropped", dropped, 1);
      checkOutput("prerst_playing", playing, 1);
      checkOutput("prerst_led", led, 4);
      checkOutput("prerst_entries", entries, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncrst_led", led, 0);
      checkOutput("asyncrst_playing", playing, 0);
      checkOutput("asyncrst_entries", entries, 0);
      checkOutput("asyncrst_dropped", dropped, 0);
      exp_q.delete();
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
      checkOutput("postrst_playing", playing, 0);
      checkOutput("postrst_entries", entries, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
